// File: rtl/jtdd_snd_romarb.sv
// jtdd_snd_romarb
// Shares one 8-bit ROM port between the sound CPU and two ADPCM sample
// readers. Each requester owns a one-byte cache entry (valid, full-address
// tag, data). A miss raises a fetch through the ROM port and the returned
// byte is written into the requester's entry.
//
// Ports
//   clk, rstn            : 24 MHz clock, asynchronous active-low reset
//   cpu_addr/cs/data/ok  : sound CPU ROM request (15-bit byte address)
//   ad0_addr/cs/data/ok  : ADPCM0 sample request (16-bit byte address)
//   ad1_addr/cs/data/ok  : ADPCM1 sample request (16-bit byte address)
//   rom_addr/cs          : shared ROM request (18-bit byte address)
//   rom_data/ok          : shared ROM response
module jtdd_snd_romarb #(
    parameter logic [17:0] CPU_OFFSET = 18'h00000,
    parameter logic [17:0] AD0_OFFSET = 18'h10000,
    parameter logic [17:0] AD1_OFFSET = 18'h20000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [14:0] cpu_addr,
    input  logic        cpu_cs,
    output logic [7:0]  cpu_data,
    output logic        cpu_ok,
    input  logic [15:0] ad0_addr,
    input  logic        ad0_cs,
    output logic [7:0]  ad0_data,
    output logic        ad0_ok,
    input  logic [15:0] ad1_addr,
    input  logic        ad1_cs,
    output logic [7:0]  ad1_data,
    output logic        ad1_ok,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] G_CPU = 2'd0;
    localparam logic [1:0] G_AD0 = 2'd1;
    localparam logic [1:0] G_AD1 = 2'd2;

    state_t      st, st_nx;
    logic [2:0]  valid;
    logic [14:0] cpu_tag;
    logic [15:0] ad0_tag, ad1_tag;
    logic [1:0]  gnt;
    logic [15:0] gaddr;
    logic        ptr;       // 0: prefer ADPCM0 when both ADPCM channels wait
    logic [1:0]  starv;     // consecutive CPU grants that passed over ADPCM

    logic        cpu_pend, ad0_pend, ad1_pend, ad_pend, any_pend, force_ad;
    logic [1:0]  sel;
    logic [15:0] sel_addr;
    logic [17:0] sel_off;

    assign cpu_ok = cpu_cs & valid[0] & (cpu_tag == cpu_addr);
    assign ad0_ok = ad0_cs & valid[1] & (ad0_tag == ad0_addr);
    assign ad1_ok = ad1_cs & valid[2] & (ad1_tag == ad1_addr);

    assign cpu_pend = cpu_cs & ~cpu_ok;
    assign ad0_pend = ad0_cs & ~ad0_ok;
    assign ad1_pend = ad1_cs & ~ad1_ok;
    assign ad_pend  = ad0_pend | ad1_pend;
    assign any_pend = cpu_pend | ad_pend;
    assign force_ad = (starv == 2'd2) & ad_pend;

    assign rom_cs = (st != IDLE);

    // Grant selection, only consumed in IDLE
    always_comb begin
        sel      = G_CPU;
        sel_addr = {1'b0, cpu_addr};
        sel_off  = CPU_OFFSET;
        if (ad_pend && (!cpu_pend || force_ad)) begin
            if (ad0_pend && (!ad1_pend || !ptr)) begin
                sel      = G_AD0;
                sel_addr = ad0_addr;
                sel_off  = AD0_OFFSET;
            end else begin
                sel      = G_AD1;
                sel_addr = ad1_addr;
                sel_off  = AD1_OFFSET;
            end
        end
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (any_pend) st_nx = ISSUE;
            ISSUE:   st_nx = WAIT;
            WAIT:    if (rom_ok) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else       st <= st_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid    <= 3'b000;
            cpu_tag  <= '0;
            ad0_tag  <= '0;
            ad1_tag  <= '0;
            cpu_data <= '0;
            ad0_data <= '0;
            ad1_data <= '0;
            gnt      <= G_CPU;
            gaddr    <= '0;
            rom_addr <= '0;
            ptr      <= 1'b0;
            starv    <= '0;
        end else begin
            if (st == IDLE) begin
                // the starvation count only matters while ADPCM is waiting
                if (!ad_pend) starv <= '0;
                if (any_pend) begin
                    gnt      <= sel;
                    gaddr    <= sel_addr;
                    rom_addr <= sel_off + {2'b00, sel_addr};   // wraps mod 2^18
                    if (sel == G_CPU) begin
                        if (ad_pend && starv != 2'd2) starv <= starv + 2'd1;
                    end else begin
                        ptr   <= ~ptr;
                        starv <= '0;
                    end
                end
            end
            if (st == WAIT && rom_ok) begin
                case (gnt)
                    G_CPU: begin
                        cpu_tag  <= gaddr[14:0];
                        cpu_data <= rom_data;
                        valid[0] <= 1'b1;
                    end
                    G_AD0: begin
                        ad0_tag  <= gaddr;
                        ad0_data <= rom_data;
                        valid[1] <= 1'b1;
                    end
                    default: begin
                        ad1_tag  <= gaddr;
                        ad1_data <= rom_data;
                        valid[2] <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
